// File: rtl/bi_seg_encoder_if.sv
// bi_seg_encoder_if: word source, encoded bus and statistics signals of the bus-invert encoder
interface bi_seg_encoder_if #(
    parameter int WIDTH = 32,
    parameter int SEGMENTS = 4,
    parameter int CNT_W = 32
);
    logic [WIDTH-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic bi_en;
    logic [WIDTH-1:0] out_data;
    logic [SEGMENTS-1:0] out_inv;
    logic out_valid;
    logic out_ready;
    logic stat_clr;
    logic [CNT_W-1:0] toggle_cnt;
    modport slave (
        input in_data, in_valid, bi_en, out_ready, stat_clr,
        output in_ready, out_data, out_inv, out_valid, toggle_cnt
    );
    modport master (
        output in_data, in_valid, bi_en, out_ready, stat_clr,
        input in_ready, out_data, out_inv, out_valid, toggle_cnt
    );
endinterface

// File: rtl/bi_seg_encoder.sv
// bi_seg_encoder: segmented bus-invert encoder with valid/ready flow control and toggle statistics
module bi_seg_encoder #(
    parameter int WIDTH = 32,
    parameter int SEGMENTS = 4,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    bi_seg_encoder_if.slave io_bus
);
    localparam int SW = WIDTH / SEGMENTS;
    localparam int DW = $clog2(SW + 2);
    localparam int TW = $clog2(WIDTH + SEGMENTS + 1);
    localparam int SUM_W = (CNT_W > TW ? CNT_W : TW) + 1;
    logic [WIDTH-1:0] r_data, w_data;
    logic [SEGMENTS-1:0] r_inv, w_inv;
    logic r_valid, w_acc;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [DW-1:0] w_d;
    logic [TW-1:0] w_t;
    logic [SUM_W-1:0] w_sum;
    assign io_bus.in_ready = !r_valid || io_bus.out_ready;
    assign w_acc = io_bus.in_valid && (!r_valid || io_bus.out_ready);
    assign io_bus.out_data = r_data;
    assign io_bus.out_inv = r_inv;
    assign io_bus.out_valid = r_valid;
    assign io_bus.toggle_cnt = r_cnt;
    // Encode each slice against what the bus currently carries, its own invert line included
    always_comb begin
        w_data = io_bus.in_data;
        w_inv = '0;
        w_d = '0;
        for (int k = 0; k < SEGMENTS; k++) begin
            w_d = DW'($countones(io_bus.in_data[k*SW +: SW] ^ r_data[k*SW +: SW])) + DW'(r_inv[k]);
            w_inv[k] = io_bus.bi_en && (({w_d, 1'b0} > (DW+1)'(SW + 1)) ||
                       (({w_d, 1'b0} == (DW+1)'(SW + 1)) && r_inv[k]));
            w_data[k*SW +: SW] = w_inv[k] ? ~io_bus.in_data[k*SW +: SW] : io_bus.in_data[k*SW +: SW];
        end
    end
    // Toggles the new word drives onto the bus, accumulated with saturation
    always_comb begin
        w_t = TW'($countones({w_inv, w_data} ^ {r_inv, r_data}));
        w_sum = SUM_W'(r_cnt) + SUM_W'(w_t);
        w_cnt_next = (w_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : w_sum[CNT_W-1:0];
    end
    // Bus register: load on accept, drop valid once consumed, data holds its last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_inv <= '0;
            r_valid <= 1'b0;
        end else if (w_acc) begin
            r_data <= w_data;
            r_inv <= w_inv;
            r_valid <= 1'b1;
        end else if (io_bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end
    // Toggle counter: a clear discards the toggles of a coincident accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else r_cnt <= io_bus.stat_clr ? '0 : w_acc ? w_cnt_next : r_cnt;
    end
endmodule

// File: tb/tb_bi_seg_encoder.sv
// tb_bi_seg_encoder: directed checks on small configurations plus scoreboarded random traffic
module tb_bi_seg_encoder;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0] i;
        logic [31:0] c;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    exp_t q[$];
    exp_t e;
    logic mv;
    logic [31:0] mb, mc, nd, x;
    logic [3:0] mp, ni;
    logic iv, ordy, en, acc, clr;
    longint s;
    always #5 clk = ~clk;
    bi_seg_encoder_if #(.WIDTH(8), .SEGMENTS(1), .CNT_W(4)) a ();
    bi_seg_encoder_if #(.WIDTH(8), .SEGMENTS(2), .CNT_W(32)) b ();
    bi_seg_encoder_if #(.WIDTH(6), .SEGMENTS(2), .CNT_W(32)) c ();
    bi_seg_encoder_if #(.WIDTH(32), .SEGMENTS(4), .CNT_W(32)) m ();
    bi_seg_encoder #(.WIDTH(8), .SEGMENTS(1), .CNT_W(4)) u_a (.clk(clk), .rst(rst), .io_bus(a.slave));
    bi_seg_encoder #(.WIDTH(8), .SEGMENTS(2), .CNT_W(32)) u_b (.clk(clk), .rst(rst), .io_bus(b.slave));
    bi_seg_encoder #(.WIDTH(6), .SEGMENTS(2), .CNT_W(32)) u_c (.clk(clk), .rst(rst), .io_bus(c.slave));
    bi_seg_encoder #(.WIDTH(32), .SEGMENTS(4), .CNT_W(32)) u_m (.clk(clk), .rst(rst), .io_bus(m.slave));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic void enc(input logic [31:0] xi, input logic [31:0] bi, input logic [3:0] pi,
                                input logic eni, output logic [31:0] ndo, output logic [3:0] nio);
        int c0, c1;
        ndo = xi;
        nio = '0;
        if (eni) begin
            for (int k = 0; k < 4; k++) begin
                c0 = $countones(xi[k*8 +: 8] ^ bi[k*8 +: 8]) + (pi[k] ? 1 : 0);
                c1 = $countones(~xi[k*8 +: 8] ^ bi[k*8 +: 8]) + (pi[k] ? 0 : 1);
                if (c1 < c0 || (c1 == c0 && pi[k])) begin
                    nio[k] = 1'b1;
                    ndo[k*8 +: 8] = ~xi[k*8 +: 8];
                end
            end
        end
    endfunction
    task automatic send_a(input logic [7:0] d, input logic en_i, input logic clr_i);
        @(negedge clk);
        a.in_data = d;
        a.bi_en = en_i;
        a.stat_clr = clr_i;
        a.in_valid = 1'b1;
        @(negedge clk);
        a.in_valid = 1'b0;
        a.stat_clr = 1'b0;
    endtask
    task automatic send_b(input logic [7:0] d);
        @(negedge clk);
        b.in_data = d;
        b.in_valid = 1'b1;
        @(negedge clk);
        b.in_valid = 1'b0;
    endtask
    task automatic send_c(input logic [5:0] d);
        @(negedge clk);
        c.in_data = d;
        c.in_valid = 1'b1;
        @(negedge clk);
        c.in_valid = 1'b0;
    endtask
    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        {a.in_valid, a.stat_clr, a.in_data} = '0;
        {a.out_ready, a.bi_en} = 2'b11;
        {b.in_valid, b.stat_clr, b.in_data} = '0;
        {b.out_ready, b.bi_en} = 2'b11;
        {c.in_valid, c.stat_clr, c.in_data} = '0;
        {c.out_ready, c.bi_en} = 2'b11;
        {m.in_valid, m.stat_clr, m.in_data} = '0;
        {m.out_ready, m.bi_en} = 2'b11;
        #12;
        chk("rst_a_data", a.out_data, 0);
        chk("rst_a_inv", a.out_inv, 0);
        chk("rst_a_valid", a.out_valid, 0);
        chk("rst_a_cnt", a.toggle_cnt, 0);
        chk("rst_a_ready", a.in_ready, 1);
        chk("rst_m_data", m.out_data, 0);
        chk("rst_m_valid", m.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        send_a(8'hFF, 1, 0);
        chk("s1_w1_data", a.out_data, 8'h00);
        chk("s1_w1_inv", a.out_inv, 1);
        chk("s1_w1_cnt", a.toggle_cnt, 1);
        chk("s1_w1_valid", a.out_valid, 1);
        send_a(8'h0F, 1, 0);
        chk("s1_w2_data", a.out_data, 8'hF0);
        chk("s1_w2_inv", a.out_inv, 1);
        chk("s1_w2_cnt", a.toggle_cnt, 5);
        send_b(8'hF1);
        chk("s2_data", b.out_data, 8'h01);
        chk("s2_inv", b.out_inv, 2'b10);
        chk("s2_cnt", b.toggle_cnt, 2);
        send_c(6'b000011);
        chk("tie_data", c.out_data, 6'b000011);
        chk("tie_inv", c.out_inv, 2'b00);
        chk("tie_cnt", c.toggle_cnt, 2);
        send_c(6'b000100);
        chk("tie2_data", c.out_data, 6'b000011);
        chk("tie2_inv", c.out_inv, 2'b01);
        chk("tie2_cnt", c.toggle_cnt, 3);
        pulse_rst();
        @(negedge clk);
        a.in_data = 8'h12;
        a.bi_en = 1'b1;
        a.in_valid = 1'b1;
        a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a.in_data = 8'h34;
            chk("bp_ready", a.in_ready, 0);
            chk("bp_data", a.out_data, 8'h12);
            chk("bp_valid", a.out_valid, 1);
        end
        a.out_ready = 1'b1;
        #1 chk("bp_ready_up", a.in_ready, 1);
        @(negedge clk);
        a.in_valid = 1'b0;
        chk("bp_new_data", a.out_data, 8'h34);
        chk("bp_new_inv", a.out_inv, 0);
        chk("bp_cnt", a.toggle_cnt, 5);
        pulse_rst();
        send_a(8'h00, 1, 0);
        send_a(8'hFF, 0, 0);
        chk("pass_data", a.out_data, 8'hFF);
        chk("pass_inv", a.out_inv, 0);
        chk("pass_cnt", a.toggle_cnt, 8);
        send_a(8'h00, 0, 0);
        chk("sat_cnt1", a.toggle_cnt, 15);
        send_a(8'hFF, 0, 0);
        chk("sat_cnt2", a.toggle_cnt, 15);
        send_a(8'h00, 0, 1);
        chk("clr_cnt", a.toggle_cnt, 0);
        chk("clr_data", a.out_data, 8'h00);
        send_a(8'hFF, 0, 0);
        chk("after_clr_cnt", a.toggle_cnt, 8);
        @(negedge clk);
        a.in_data = 8'h55;
        a.bi_en = 1'b0;
        a.in_valid = 1'b1;
        a.out_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", a.out_data, 0);
        chk("arst_inv", a.out_inv, 0);
        chk("arst_valid", a.out_valid, 0);
        chk("arst_cnt", a.toggle_cnt, 0);
        chk("arst_ready", a.in_ready, 1);
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_a(8'h0F, 1, 0);
        chk("post_rst_data", a.out_data, 8'h0F);
        chk("post_rst_cnt", a.toggle_cnt, 4);
        mv = 1'b0;
        mb = '0;
        mp = '0;
        mc = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            chk("m_valid", m.out_valid, mv);
            iv = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 3) != 0;
            en = $urandom_range(0, 4) != 0;
            x = (i % 3 == 0) ? (mb ^ (32'h1 << $urandom_range(0, 31))) : $urandom;
            acc = iv && (!mv || ordy);
            clr = acc && ($urandom_range(0, 15) == 0);
            m.in_valid = iv;
            m.in_data = x;
            m.bi_en = en;
            m.out_ready = ordy;
            m.stat_clr = clr;
            #1 chk("m_in_ready", m.in_ready, !mv || ordy);
            if (mv && ordy) begin
                if (q.size() == 0) chk("m_q_nonempty", q.size(), 1);
                else begin
                    e = q.pop_front();
                    chk("m_data", m.out_data, e.d);
                    chk("m_inv", m.out_inv, e.i);
                    chk("m_cnt", m.toggle_cnt, e.c);
                end
            end
            if (acc) begin
                enc(x, mb, mp, en, nd, ni);
                s = longint'(mc) + $countones({ni, nd} ^ {mp, mb});
                mc = clr ? 32'h0 : (s > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : s[31:0]);
                mb = nd;
                mp = ni;
                q.push_back('{nd, ni, mc});
            end
            mv = acc ? 1'b1 : (ordy ? 1'b0 : mv);
        end
        @(negedge clk);
        chk("m_valid_end", m.out_valid, mv);
        m.in_valid = 1'b0;
        m.out_ready = 1'b1;
        m.stat_clr = 1'b0;
        #1;
        if (mv) begin
            if (q.size() == 0) chk("m_q_nonempty", q.size(), 1);
            else begin
                e = q.pop_front();
                chk("m_data", m.out_data, e.d);
                chk("m_inv", m.out_inv, e.i);
                chk("m_cnt", m.toggle_cnt, e.c);
            end
        end
        @(negedge clk);
        chk("m_drained", m.out_valid, 0);
        chk("m_q_left", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bi_seg_encoder.md
# bi_seg_encoder

Parametrised, segmented bus-invert encoder with valid/ready flow control and a toggle-statistics counter. The input word is split into SEGMENTS equal slices. Each slice has its own invert line, and the decision for a slice counts the transition on that invert line itself. The block sits between a word source and a long off-block bus, registers the encoded word for one cycle, and counts the line toggles actually driven onto the bus.

## Interface
- WIDTH, 32, data bus width; must be a multiple of SEGMENTS
- SEGMENTS, 4, number of independently inverted slices; SW = WIDTH/SEGMENTS
- CNT_W, 32, width of the toggle counter
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  raw word
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- bi_en  input  1  1 = encode; 0 = pass-through with all inv lines 0; sampled with the word
- out_data  output  WIDTH  encoded bus data (registered)
- out_inv  output  SEGMENTS  per-slice invert flags (registered); bit k covers out_data[k*SW +: SW]
- out_valid  output  1  out_data/out_inv hold an unconsumed word
- out_ready  input  1  sink accepts the word
- stat_clr  input  1  synchronous clear of toggle_cnt
- toggle_cnt  output  CNT_W  saturating count of toggles on {out_inv, out_data}

## Operation
- Reset values: out_data = 0, out_inv = 0, out_valid = 0, toggle_cnt = 0. in_ready = 1 after reset.
- Bus state is the current {out_data, out_inv} registers. There is no separate previous-data register, so the reference state is always what the bus actually carries.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput with one word per cycle.
- Accept: in_valid && in_ready. On accept, the output registers load the encoded word and out_valid <= 1.
- No accept and out_ready = 1: out_valid <= 0. out_data and out_inv keep their last value, because the bus holds its state.
- While out_valid && !out_ready: out_data, out_inv and out_valid are held stable.
- Per-slice decision for slice k, with x = in_data slice, b = out_data slice, p = out_inv[k]:
  - d = popcount(x ^ b) + p. This is the cost of sending x non-inverted with inv=0, over SW+1 lines.
  - The cost of sending ~x with inv=1 is SW+1-d.
  - If 2d > SW+1: send ~x with inv=1.
  - If 2d < SW+1: send x with inv=0.
  - If 2d == SW+1 (only possible when SW is odd): keep inv = p and send x if p=0, ~x if p=1.
- bi_en=0 on accept: out_data <= in_data, out_inv <= 0.
- Toggle count, computed on each accept: t = popcount({new_out_inv,new_out_data} ^ {out_inv,out_data}), with a maximum of WIDTH+SEGMENTS.
  - toggle_cnt <= min(toggle_cnt + t, 2^CNT_W - 1).
  - stat_clr=1 sets toggle_cnt <= 0. It wins over a coincident accept, and that word's t is discarded.
- All arithmetic uses unsigned widths large enough for the counts: $clog2(SW+2) for d, and CNT_W+1 for the sum before saturation.

## Timing
- Latency: a word accepted at edge N appears on out_data/out_inv/out_valid after edge N. This is 1 cycle.
- Back-to-back accepts encode each word against the word accepted on the previous accept, not against a word still in flight.
- Reset asserted mid-stream: all outputs return to their reset values asynchronously and any pending word is dropped. The first word after reset is encoded against all-zero bus state.
- No combinational path from in_data to any output. in_ready depends only on out_valid and out_ready.

## Test plan
- WIDTH=8, SEGMENTS=1, from reset, send 0xFF then 0x0F:
  - First word: out_data=0x00, out_inv=1, toggle_cnt=1.
  - Second word (d=5): out_data=0xF0, out_inv=1, toggle_cnt=5.
- WIDTH=8, SEGMENTS=2, from reset, send 0xF1: out_data=0x01, out_inv=2'b10, toggle_cnt=2.
- WIDTH=6, SEGMENTS=2 (tie case), from reset:
  - Send 6'b000011: tie, out_data=6'b000011, out_inv=2'b00.
  - Then send 6'b000100: out_data=6'b000011, out_inv=2'b01, toggle_cnt increments by 1.
- Backpressure, WIDTH=8, SEGMENTS=1:
  - Send 0x12 and hold out_ready=0 for 3 cycles with in_valid=1 on 0x34. Required: in_ready=0, out_data=0x12 stable, 0x34 not accepted.
  - Then raise out_ready. Required: 0x34 appears the next cycle, encoded against 0x12 (out_inv=0).
- bi_en=0 with 0xFF after 0x00: out_data=0xFF, out_inv=0, toggle_cnt += 8.
- CNT_W=4, repeatedly alternate 0x00/0xFF with bi_en=0: toggle_cnt saturates at 15.
  - Pulsing stat_clr during an accept gives toggle_cnt=0.
  - Asserting rst mid-stream immediately zeroes all outputs.
